// File: rtl/ms_timer_pkg.sv
// Shared types and default constants for the millisecond countdown timer.
// MS_TIMER_AUTORELOAD_EN selects periodic reload in ms_timer; this package does not depend on it.
package ms_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CYCLES_PER_MS_DEF = 20000;
  localparam int CNT_W_DEF         = 32;

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler that divides clk down to a one-cycle tick every CYCLES_PER_MS cycles.
// clr forces the count back to 0; the tick fires on the cycle the count wraps.
module ms_tick_gen #(
  parameter int CYCLES_PER_MS = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(CYCLES_PER_MS);
  localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_MS - 1);

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = en && w_wrap;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ms_timer.sv
// Programmable millisecond countdown timer with sticky expired flag and one-cycle irq.
// Define MS_TIMER_AUTORELOAD_EN to reload the written delay at each expiry (periodic mode).
module ms_timer
  import ms_timer_pkg::*;
#(
  parameter int CYCLES_PER_MS = CYCLES_PER_MS_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             cancel,
  input  logic             ack,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             irq
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_remaining;
  logic             r_expired;
  logic             r_irq;
  logic             w_tick;
  logic             w_expire;
  logic             w_running;
`ifdef MS_TIMER_AUTORELOAD_EN
  logic [CNT_W-1:0] r_reload;
`endif

  assign w_running = (r_state == RUN);
  assign w_expire  = w_tick && w_running && (r_remaining == CNT_W'(1));

  ms_tick_gen #(
    .CYCLES_PER_MS(CYCLES_PER_MS)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (wr_en || cancel || !w_running),
    .en  (w_running),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (wr_en) begin
      w_state_next = (wr_data != '0) ? RUN : DONE;
    end else if (cancel && w_running) begin
      w_state_next = IDLE;
    end else if (ack && (r_state == DONE)) begin
      w_state_next = IDLE;
    end else if (w_expire) begin
`ifdef MS_TIMER_AUTORELOAD_EN
      w_state_next = RUN;
`else
      w_state_next = DONE;
`endif
    end
  end

  always_comb begin
    busy      = w_running;
    remaining = r_remaining;
    expired   = r_expired;
    irq       = r_irq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_expired   <= 1'b0;
      r_irq       <= 1'b0;
`ifdef MS_TIMER_AUTORELOAD_EN
      r_reload    <= '0;
`endif
    end else begin
      r_irq <= 1'b0;
      if (wr_en) begin
`ifdef MS_TIMER_AUTORELOAD_EN
        r_reload <= wr_data;
`endif
        if (wr_data != '0) begin
          r_remaining <= wr_data;
          r_expired   <= 1'b0;
        end else begin
          r_remaining <= '0;
          r_expired   <= 1'b1;
          r_irq       <= 1'b1;
        end
      end else if (cancel && w_running) begin
        r_remaining <= '0;
        r_expired   <= 1'b0;
      end else if (ack && (r_state == DONE)) begin
        r_expired <= 1'b0;
      end else begin
        // An ack while running only clears the flag; a coinciding expiry re-asserts it.
        if (ack) begin
          r_expired <= 1'b0;
        end
        if (w_expire) begin
          r_expired <= 1'b1;
          r_irq     <= 1'b1;
`ifdef MS_TIMER_AUTORELOAD_EN
          r_remaining <= r_reload;
`else
          r_remaining <= '0;
`endif
        end else if (w_tick && w_running && (r_remaining != '0)) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/ms_timer.md
Name: ms_timer

Overview:
- Programmable millisecond countdown timer; the CPU-writable complement to the free-running millisecond counter.
- CPU writes a delay in ms. The block prescales the system clock to 1 ms ticks and counts the delay down.
- On expiry it raises a sticky expired flag and a one-cycle irq pulse.
- Sits on the memory-mapped peripheral bus next to the ms counter. Used for delays and watchdog-style timeouts.

Parameters:
- CYCLES_PER_MS, 20000: clock cycles per 1 ms tick. Legal range 2..65535.
- CNT_W, 32: width of the ms delay and remaining count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  load strobe; wr_data is sampled on this cycle.
- wr_data  in  CNT_W  delay in ms.
- cancel  in  1  abort a running countdown.
- ack  in  1  clear the expired flag.
- remaining  out  CNT_W  ms left in the countdown.
- busy  out  1  countdown in progress.
- expired  out  1  sticky done flag.
- irq  out  1  one-cycle pulse on expiry.

Behaviour:
- Reset: state=IDLE, prescaler=0, remaining=0, busy=0, expired=0, irq=0. Reset mid-run aborts the countdown with no irq.
- States:
  - IDLE: no countdown; expired=0.
  - RUN: counting down; busy=1.
  - DONE: countdown finished; expired=1.
- Priority per cycle: rst > wr_en > cancel > ack > prescaler tick.
- wr_en, wr_data!=0, from any state:
  - remaining<=wr_data, prescaler<=0, expired<=0, state<=RUN.
  - busy=1 from the next cycle.
  - A write during RUN restarts the countdown.
- wr_en, wr_data==0:
  - state<=DONE, expired<=1, irq<=1, remaining=0, busy stays 0.
  - expired and irq are visible 1 cycle after the write.
- RUN counting:
  - Prescaler counts 0..CYCLES_PER_MS-1, then wraps to 0. The wrap cycle is the tick, and remaining decrements on the tick.
  - A write sampled at edge t0 yields ticks at edges t0+k*CYCLES_PER_MS.
  - Delay of N ms: remaining reaches 0 at edge t0+N*CYCLES_PER_MS.
  - On that same edge: state<=DONE, expired<=1, irq<=1, busy<=0.
- irq is high exactly one cycle per expiry. expired holds until ack or wr_en.
- cancel:
  - In RUN: state<=IDLE, remaining<=0, prescaler<=0, busy<=0, no irq.
  - In IDLE or DONE: ignored.
- ack:
  - In DONE: expired<=0, state<=IDLE.
  - Elsewhere: ignored.
- Prescaler width: ceil(log2(CYCLES_PER_MS)). No arithmetic wrap on remaining; it never decrements below 0.

Optional Feature:
- Macro MS_TIMER_AUTORELOAD_EN.
- Defined: wr_data is also latched into a reload register.
  - At expiry, remaining<=reload, state stays RUN, busy stays 1.
  - expired<=1 and irq pulses every period.
  - cancel stops the timer. ack clears expired without stopping it.
  - Writing 0 behaves as one-shot immediate expiry.
- Undefined: one-shot only; no reload register exists.

Decomposition:
- Package ms_timer_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default constants CYCLES_PER_MS_DEF=20000 and CNT_W_DEF=32.
- Sub-module ms_tick_gen: prescaler counter with a synchronous clear input and a one-cycle tick output.
  - Also reusable by the free-running ms counter.
- ms_timer holds the FSM and the remaining/reload registers.

Test Plan (CYCLES_PER_MS=4 for simulation):
- Reset: hold rst 2 cycles with wr_en=1 -> remaining=0, busy=0, expired=0, irq=0 throughout.
- One-shot: write 3 at t0 ->
  - busy=1 at t0+1;
  - remaining 2/1/0 at edges t0+4/8/12;
  - expired=1 and irq=1 after t0+12, irq=0 after t0+13, busy=0.
- Zero write: write 0 -> expired=1 and irq=1 one cycle later; busy never 1. Then ack -> expired=0.
- Cancel: write 5, assert cancel when remaining=2 -> next cycle busy=0, remaining=0; no irq for 40 cycles.
- Restart and priority:
  - Write 5 while remaining=1 -> remaining=5, next tick 4 cycles later.
  - In DONE, assert wr_en(2) and ack together -> RUN with remaining=2, expired=0.
- Autoreload (MS_TIMER_AUTORELOAD_EN): write 2 -> irq pulses every 8 cycles for 4 periods, busy stays 1. cancel -> busy=0, no further irq.
